// File: rtl/mst_lb_fifo_pkg.sv
// Shared definitions for the loopback elastic buffer: widths, thresholds, gate states.
package mst_lb_fifo_pkg;

   localparam int unsigned LbDw      = 16;
   localparam int unsigned LbAw      = 9;
   localparam int unsigned LbStartTh = 256;
   localparam int unsigned LbAfullTh = 480;
   localparam int unsigned LbTmoCyc  = 1024;

   // Fill/drain gate: FILL holds data back, DRAIN lets the prefetch stage pull words.
   typedef enum logic {
      StFill  = 1'b0,
      StDrain = 1'b1
   } lb_gate_e;

endpackage

// File: rtl/mst_lb_fifo_if.sv
// Receive-side write strobe, prefetch request/reply and buffer status of the loopback FIFO.
interface mst_lb_fifo_if #(
   parameter int unsigned DW = 16,
   parameter int unsigned AW = 9
);

   logic          wr_vld;
   logic [DW-1:0] wr_dat;
   logic          gen_req;
   logic [DW-1:0] gen_dat;
   logic          gen_vld;
   logic          lb_avail;
   logic          lb_full;
   logic          lb_afull;
   logic [AW:0]   lb_level;
   logic          ovf_err;
   logic          udf_err;

   // Producer/consumer side: drives words and requests, observes replies and status.
   modport master (
      output wr_vld, wr_dat, gen_req,
      input  gen_dat, gen_vld, lb_avail, lb_full, lb_afull, lb_level, ovf_err, udf_err
   );

   // The FIFO itself.
   modport slave (
      input  wr_vld, wr_dat, gen_req,
      output gen_dat, gen_vld, lb_avail, lb_full, lb_afull, lb_level, ovf_err, udf_err
   );

endinterface

// File: rtl/mst_lb_ram.sv
// Simple dual-port synchronous RAM: one write port, one registered read port, no reset.
module mst_lb_ram #(
   parameter int unsigned DW = 16,
   parameter int unsigned AW = 9
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [0:(1 << AW) - 1];

   // Write port and registered read port; rdata holds when no read is issued.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/mst_lb_fifo.sv
// Loopback elastic buffer: captures received words and replays them to the prefetch stage
// once the fill/drain gate opens (start threshold reached or receive stream gone idle).
module mst_lb_fifo
   import mst_lb_fifo_pkg::*;
#(
   parameter int unsigned DW       = LbDw,
   parameter int unsigned AW       = LbAw,
   parameter int unsigned START_TH = LbStartTh,
   parameter int unsigned AFULL_TH = LbAfullTh,
   parameter int unsigned TMO_CYC  = LbTmoCyc
) (
   input logic          clk,
   input logic          rst_n,
   input logic          clr,
   mst_lb_fifo_if.slave bus
);

   localparam int unsigned IW = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;

   logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]   level, level_nxt;
   logic [IW-1:0] idle_q, idle_d;
   lb_gate_e      gate_q, gate_d;
   logic          ovf_q, ovf_d, udf_q, udf_d;
   logic          gen_vld_q;
   logic          have_dat_q;
   logic          full, empty, avail, wr_en, rd_en;
   logic [DW-1:0] ram_rdata;

   assign level = wr_ptr_q - rd_ptr_q;
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign avail = (gate_q == StDrain) && !empty;
   assign wr_en = bus.wr_vld && !full && !clr;
   assign rd_en = bus.gen_req && avail && !clr;

   mst_lb_ram #(
      .DW (DW),
      .AW (AW)
   ) u_ram (
      .clk   (clk),
      .we    (wr_en),
      .waddr (wr_ptr_q[AW-1:0]),
      .wdata (bus.wr_dat),
      .re    (rd_en),
      .raddr (rd_ptr_q[AW-1:0]),
      .rdata (ram_rdata)
   );

   // Next-state for pointers, sticky flags, idle counter and the fill/drain gate.
   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      idle_d    = idle_q;
      gate_d    = gate_q;
      ovf_d     = ovf_q;
      udf_d     = udf_q;
      level_nxt = level;
      if (clr) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         idle_d   = '0;
         gate_d   = StFill;
         ovf_d    = 1'b0;
         udf_d    = 1'b0;
      end else begin
         if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
         if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
         level_nxt = wr_ptr_d - rd_ptr_d;
         if (bus.wr_vld && full) ovf_d = 1'b1;
         if (bus.gen_req && !avail) udf_d = 1'b1;
         if (bus.wr_vld || (gate_q == StDrain)) begin
            idle_d = '0;
         end else if (32'(idle_q) != TMO_CYC - 1) begin
            idle_d = idle_q + 1'b1;
         end
         unique case (gate_q)
            StFill: begin
               // Threshold looks at the post-edge level so the gate opens alongside it.
               if ((32'(level_nxt) >= START_TH) ||
                   ((32'(idle_q) == TMO_CYC - 1) && !empty)) begin
                  gate_d = StDrain;
               end
            end
            StDrain: begin
               if (empty || (level_nxt == '0)) gate_d = StFill;
            end
            default: gate_d = StFill;
         endcase
      end
   end

   // State registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         idle_q     <= '0;
         gate_q     <= StFill;
         ovf_q      <= 1'b0;
         udf_q      <= 1'b0;
         gen_vld_q  <= 1'b0;
         have_dat_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         idle_q     <= idle_d;
         gate_q     <= gate_d;
         ovf_q      <= ovf_d;
         udf_q      <= udf_d;
         gen_vld_q  <= rd_en;
         have_dat_q <= have_dat_q | rd_en;
      end
   end

   // The RAM read register has no reset, so gen_dat reads as zero until the first served read.
   assign bus.gen_dat  = have_dat_q ? ram_rdata : '0;
   assign bus.gen_vld  = gen_vld_q;
   assign bus.lb_avail = avail;
   assign bus.lb_full  = full;
   assign bus.lb_afull = (32'(level) >= AFULL_TH);
   assign bus.lb_level = level;
   assign bus.ovf_err  = ovf_q;
   assign bus.udf_err  = udf_q;

endmodule

// File: tb/tb_mst_lb_fifo.sv
// Self-checking bench for mst_lb_fifo: randomized stimulus, queue-based reference model,
// scoreboard of expected replayed words checked by an independent monitor.
module tb_mst_lb_fifo;

   localparam int DW       = 16;
   localparam int AW       = 9;
   localparam int DEPTH    = 512;
   localparam int START_TH = 256;
   localparam int AFULL_TH = 480;
   localparam int TMO_CYC  = 1024;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic clr = 1'b0;

   mst_lb_fifo_if #(.DW(DW), .AW(AW)) bus ();

   mst_lb_fifo #(
      .DW       (DW),
      .AW       (AW),
      .START_TH (START_TH),
      .AFULL_TH (AFULL_TH),
      .TMO_CYC  (TMO_CYC)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: contents as a plain queue, gate as a flag, idle as an integer.
   logic [DW-1:0] m_q[$];
   logic [DW-1:0] exp_q[$];
   bit            m_drain;
   int            m_idle;
   bit            m_ovf, m_udf, m_vld;
   logic [DW-1:0] m_last;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
      end
   endtask

   function automatic bit m_avail();
      return m_drain && (m_q.size() > 0);
   endfunction

   task automatic check_status(input string tag);
      chk({tag, "_level"}, 64'(bus.lb_level), 64'(m_q.size()));
      chk({tag, "_full"},  64'(bus.lb_full),  64'(m_q.size() == DEPTH));
      chk({tag, "_afull"}, 64'(bus.lb_afull), 64'(m_q.size() >= AFULL_TH));
      chk({tag, "_avail"}, 64'(bus.lb_avail), 64'(m_avail()));
      chk({tag, "_ovf"},   64'(bus.ovf_err),  64'(m_ovf));
      chk({tag, "_udf"},   64'(bus.udf_err),  64'(m_udf));
      chk({tag, "_vld"},   64'(bus.gen_vld),  64'(m_vld));
      chk({tag, "_dat"},   64'(bus.gen_dat),  64'(m_last));
   endtask

   // One clock of stimulus; called at a negedge and returns at the next negedge.
   task automatic cycle(input bit wv, input logic [DW-1:0] wd, input bit rq, input bit cl);
      bit served, wr_ok, was_drain;
      int old_n, new_n;
      bus.wr_vld  = wv;
      bus.wr_dat  = wd;
      bus.gen_req = rq;
      clr         = cl;
      served = rq && m_avail() && !cl;
      if (served) exp_q.push_back(m_q[0]);
      @(posedge clk);
      old_n     = m_q.size();
      was_drain = m_drain;
      if (cl) begin
         m_q.delete();
         m_ovf = 0; m_udf = 0; m_idle = 0; m_drain = 0;
      end else begin
         wr_ok = wv && (old_n < DEPTH);
         if (wv && !wr_ok) m_ovf = 1;
         if (rq && !served) m_udf = 1;
         if (served) m_last = m_q.pop_front();
         if (wr_ok) m_q.push_back(wd);
         new_n = m_q.size();
         if (!was_drain) begin
            if (new_n >= START_TH || (m_idle == TMO_CYC - 1 && old_n > 0)) m_drain = 1;
         end else if (new_n == 0 || old_n == 0) begin
            m_drain = 0;
         end
         if (wv || was_drain) m_idle = 0;
         else if (m_idle < TMO_CYC - 1) m_idle++;
      end
      m_vld = served;
      @(negedge clk);
      check_status("cyc");
   endtask

   task automatic model_reset();
      m_q.delete(); exp_q.delete();
      m_drain = 0; m_idle = 0; m_ovf = 0; m_udf = 0; m_vld = 0; m_last = '0;
   endtask

   // Asynchronous reset asserted mid-cycle, released on a negedge.
   task automatic do_reset(input string tag);
      bus.wr_vld = 0; bus.gen_req = 0; clr = 0;
      #2 rst_n = 1'b0;
      model_reset();
      @(negedge clk);
      check_status(tag);
      rst_n = 1'b1;
   endtask

   // Pull words until the model is empty, letting the idle timeout open the gate if needed.
   task automatic drain_all(input string tag);
      int n = 0;
      while (m_q.size() > 0 && n < 3000) begin
         cycle(1'b0, '0, m_avail(), 1'b0);
         n++;
      end
      chk({tag, "_drain_bound"}, 64'(m_q.size()), 64'd0);
   endtask

   // Scoreboard monitor: every gen_vld must match the oldest expected word.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && bus.gen_vld) begin
            if (exp_q.size() == 0) begin
               chk("sb_unexpected_vld", 64'(bus.gen_vld), 64'd0);
            end else begin
               chk("sb_data", 64'(bus.gen_dat), 64'(exp_q.pop_front()));
            end
         end
      end
   end

   initial begin
      int n, sent;
      bus.wr_vld = 0; bus.wr_dat = '0; bus.gen_req = 0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      check_status("reset");
      rst_n = 1'b1;

      // 1: 16 words, gate opens only after the idle timeout, replay in order.
      for (int i = 0; i < 16; i++) cycle(1'b1, DW'(i), 1'b0, 1'b0);
      n = 0;
      while (!bus.lb_avail && n < 1100) begin
         cycle(1'b0, '0, 1'b0, 1'b0);
         n++;
      end
      chk("t1_idle_cycles", 64'(n), 64'd1024);
      for (int i = 0; i < 16; i++) cycle(1'b0, '0, 1'b1, 1'b0);
      chk("t1_last", 64'(m_last), 64'h000F);
      chk("t1_gate_fill", 64'(bus.lb_avail), 64'd0);

      // 2: threshold opening, then level held at 256 by matched reads and writes.
      for (int i = 0; i < 256; i++) cycle(1'b1, DW'($urandom), 1'b0, 1'b0);
      chk("t2_avail", 64'(bus.lb_avail), 64'd1);
      chk("t2_level", 64'(bus.lb_level), 64'd256);
      for (int i = 0; i < 100; i++) cycle(1'b1, DW'($urandom), 1'b1, 1'b0);
      chk("t2_level_held", 64'(bus.lb_level), 64'd256);
      drain_all("t2");

      // 3: overfill by one word, overflow flag is sticky.
      for (int i = 0; i < 513; i++) cycle(1'b1, DW'(i), 1'b0, 1'b0);
      chk("t3_full", 64'(bus.lb_full), 64'd1);
      chk("t3_ovf", 64'(bus.ovf_err), 64'd1);
      drain_all("t3");
      chk("t3_last_word", 64'(m_last), 64'd511);
      chk("t3_ovf_sticky", 64'(bus.ovf_err), 64'd1);

      // 4: request while gated (FILL) and empty; clr then wipes the flags.
      cycle(1'b0, '0, 1'b1, 1'b0);
      chk("t4_udf", 64'(bus.udf_err), 64'd1);
      cycle(1'b1, 16'h1234, 1'b1, 1'b1);
      chk("t4_clr_udf", 64'(bus.udf_err), 64'd0);

      // 5: long random stream across pointer wrap.
      sent = 0;
      n = 0;
      while (sent < 2000 && n < 20000) begin
         bit wv;
         wv = ($urandom_range(0, 99) < 70);
         if (wv) sent++;
         cycle(wv, DW'($urandom), m_avail() && ($urandom_range(0, 1) == 1), 1'b0);
         n++;
      end
      drain_all("t5");

      // 6a: clr mid-stream at level 100, next word is the first one read back.
      for (int i = 0; i < 100; i++) cycle(1'b1, DW'($urandom), 1'b0, 1'b0);
      chk("t6_level100", 64'(bus.lb_level), 64'd100);
      cycle(1'b1, 16'hFFFF, 1'b1, 1'b1);
      chk("t6_clr_level", 64'(bus.lb_level), 64'd0);
      cycle(1'b1, 16'hA5A5, 1'b0, 1'b0);
      drain_all("t6a");
      chk("t6_clr_first", 64'(m_last), 64'hA5A5);

      // 6b: reset mid-stream.
      for (int i = 0; i < 100; i++) cycle(1'b1, DW'($urandom), 1'b0, 1'b0);
      do_reset("t6_rst");
      cycle(1'b1, 16'hA5A5, 1'b0, 1'b0);
      drain_all("t6b");
      chk("t6_rst_first", 64'(bus.gen_dat), 64'hA5A5);

      @(negedge clk);
      chk("sb_empty", 64'(exp_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
